// File: rtl/ram_port_arbiter_if.sv
// Request, grant, return and RAM-control signals of the scratch RAM port arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view
// (DMA requesters plus the RAM wrapper).
interface ram_port_arbiter_if #(
    parameter int W_ADDR = 12,
    parameter int W_DATA = 64
);
    logic              wr_req0, wr_req1;
    logic [W_ADDR-1:0] wr_addr0, wr_addr1;
    logic [W_DATA-1:0] wr_data0, wr_data1;
    logic              wr_gnt0, wr_gnt1;
    logic              rd_req0, rd_req1;
    logic [W_ADDR-1:0] rd_addr0, rd_addr1;
    logic              rd_gnt0, rd_gnt1;
    logic              rd_valid0, rd_valid1;
    logic [W_DATA-1:0] rd_data;
    logic [W_ADDR-1:0] address_a;
    logic [W_DATA-1:0] data_a;
    logic              wren_a;
    logic [W_ADDR-1:0] address_b;
    logic              rden_b;
    logic [W_DATA-1:0] q_b;

    modport slave (
        input  wr_req0, wr_req1, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  rd_req0, rd_req1, rd_addr0, rd_addr1, q_b,
        output wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1, rd_valid0, rd_valid1, rd_data,
        output address_a, data_a, wren_a, address_b, rden_b
    );

    modport master (
        output wr_req0, wr_req1, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output rd_req0, rd_req1, rd_addr0, rd_addr1, q_b,
        input  wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1, rd_valid0, rd_valid1, rd_data,
        input  address_a, data_a, wren_a, address_b, rden_b
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for the DMA scratch RAM: two writers share port A, two readers share port B.
// Grants are combinational in T. RAM controls are registered for T+1. Read data returns at T+1+RD_LATENCY.
// Reads that hit the same-cycle or previous-cycle write address are stalled. There is no backpressure on return.
module ram_port_arbiter #(
    parameter int W_ADDR     = 12,
    parameter int W_DATA     = 64,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              reset_n,
    ram_port_arbiter_if.slave bus
);

    // Write side
    logic              wr_gnt0_c, wr_gnt1_c, wr_any;
    logic [W_ADDR-1:0] wr_gaddr;
    logic [W_DATA-1:0] wr_gdata;

    // Read side
    logic              rd_hit0, rd_hit1, rd_elig0, rd_elig1;
    logic              rd_gnt0_c, rd_gnt1_c, rd_any;
    logic [W_ADDR-1:0] rd_gaddr;

    // State
    logic [W_ADDR-1:0] address_a_q, address_a_d;
    logic [W_DATA-1:0] data_a_q, data_a_d;
    logic              wren_a_q, wren_a_d;
    logic [W_ADDR-1:0] address_b_q, address_b_d;
    logic              rden_b_q, rden_b_d;
    logic              wr_last_q, wr_last_d;
    logic              rd_last_q, rd_last_d;
    logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0] tag_id_q, tag_id_d;

    // Write arbitration: a sole requester wins; on contention the one not served last wins.
    always_comb begin
        wr_gnt0_c = 1'b0;
        wr_gnt1_c = 1'b0;
        if (reset_n) begin
            if (bus.wr_req0 && (!bus.wr_req1 || wr_last_q)) begin
                wr_gnt0_c = 1'b1;
            end else if (bus.wr_req1) begin
                wr_gnt1_c = 1'b1;
            end
        end
    end

    assign wr_any   = wr_gnt0_c | wr_gnt1_c;
    assign wr_gaddr = wr_gnt1_c ? bus.wr_addr1 : bus.wr_addr0;
    assign wr_gdata = wr_gnt1_c ? bus.wr_data1 : bus.wr_data0;

    // A read is held off while its address matches the write granted now or the write on port A this cycle.
    // Until that write has committed, the RAM would return stale data for that address.
    assign rd_hit0  = (wr_any && (bus.rd_addr0 == wr_gaddr)) || (wren_a_q && (bus.rd_addr0 == address_a_q));
    assign rd_hit1  = (wr_any && (bus.rd_addr1 == wr_gaddr)) || (wren_a_q && (bus.rd_addr1 == address_a_q));
    assign rd_elig0 = bus.rd_req0 && !rd_hit0;
    assign rd_elig1 = bus.rd_req1 && !rd_hit1;

    // Read arbitration among non-colliding requesters, with its own round-robin pointer.
    always_comb begin
        rd_gnt0_c = 1'b0;
        rd_gnt1_c = 1'b0;
        if (reset_n) begin
            if (rd_elig0 && (!rd_elig1 || rd_last_q)) begin
                rd_gnt0_c = 1'b1;
            end else if (rd_elig1) begin
                rd_gnt1_c = 1'b1;
            end
        end
    end

    assign rd_any   = rd_gnt0_c | rd_gnt1_c;
    assign rd_gaddr = rd_gnt1_c ? bus.rd_addr1 : bus.rd_addr0;

    // Next-state for the RAM controls and pointers.
    // A pointer moves only when something is granted, so a stalled reader keeps its turn.
    always_comb begin
        address_a_d = wr_any ? wr_gaddr : address_a_q;
        data_a_d    = wr_any ? wr_gdata : data_a_q;
        wren_a_d    = wr_any;
        wr_last_d   = wr_any ? wr_gnt1_c : wr_last_q;
        address_b_d = rd_any ? rd_gaddr : address_b_q;
        rden_b_d    = rd_any;
        rd_last_d   = rd_any ? rd_gnt1_c : rd_last_q;
    end

    // Return tag pipeline, loaded as rden_b goes to the RAM.
    // While rden_b_q is high, rd_last_q is the id of that read.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = rden_b_q;
        tag_id_d[0]  = rd_last_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    // State registers. Reset discards in-flight reads and gives requester 0 first priority.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            address_a_q <= '0;
            data_a_q    <= '0;
            wren_a_q    <= 1'b0;
            address_b_q <= '0;
            rden_b_q    <= 1'b0;
            wr_last_q   <= 1'b1;
            rd_last_q   <= 1'b1;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
        end else begin
            address_a_q <= address_a_d;
            data_a_q    <= data_a_d;
            wren_a_q    <= wren_a_d;
            address_b_q <= address_b_d;
            rden_b_q    <= rden_b_d;
            wr_last_q   <= wr_last_d;
            rd_last_q   <= rd_last_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
        end
    end

    assign bus.wr_gnt0   = wr_gnt0_c;
    assign bus.wr_gnt1   = wr_gnt1_c;
    assign bus.rd_gnt0   = rd_gnt0_c;
    assign bus.rd_gnt1   = rd_gnt1_c;
    assign bus.address_a = address_a_q;
    assign bus.data_a    = data_a_q;
    assign bus.wren_a    = wren_a_q;
    assign bus.address_b = address_b_q;
    assign bus.rden_b    = rden_b_q;
    assign bus.rd_valid0 = tag_vld_q[RD_LATENCY-1] & ~tag_id_q[RD_LATENCY-1];
    assign bus.rd_valid1 = tag_vld_q[RD_LATENCY-1] &  tag_id_q[RD_LATENCY-1];
    assign bus.rd_data   = bus.q_b;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter, including a behavioural RAM with a two-cycle read.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled on the falling edge.
// It runs directed vectors and corner sequences, then random traffic against a reference model.
module tb_ram_port_arbiter;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ram_port_arbiter_if #(.W_ADDR(12), .W_DATA(64)) bus();

    ram_port_arbiter #(.W_ADDR(12), .W_DATA(64), .RD_LATENCY(2)) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    // Initial RAM contents, used for any location not yet written.
    function automatic logic [63:0] pat(input logic [11:0] a);
        return {20'hC0DE0, a, 20'h5A5A5, a};
    endfunction

    // RAM model: port A writes on the clock edge; port B reads through two register stages.
    bit          ram_flag [0:4095];
    logic [63:0] ram_mem  [0:4095];
    logic [63:0] rd_s1;
    always @(posedge clk_in) begin
        if (bus.rden_b) rd_s1 <= ram_flag[bus.address_b] ? ram_mem[bus.address_b] : pat(bus.address_b);
        bus.q_b <= rd_s1;
        if (bus.wren_a) begin
            ram_mem[bus.address_a]  <= bus.data_a;
            ram_flag[bus.address_a] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic half();
        @(negedge clk_in);
    endtask

    task automatic idle();
        bus.wr_req0 = 1'b0; bus.wr_req1 = 1'b0; bus.rd_req0 = 1'b0; bus.rd_req1 = 1'b0;
        bus.wr_addr0 = '0; bus.wr_addr1 = '0; bus.wr_data0 = '0; bus.wr_data1 = '0;
        bus.rd_addr0 = '0; bus.rd_addr1 = '0;
    endtask

    task automatic do_reset();
        idle();
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic wq0, wq1; logic [11:0] wa0;
        logic rq0, rq1; logic [11:0] ra0, ra1;
        logic eg0, eg1, er0, er1, ewren; logic [11:0] eaa; logic erden;
    } vec_t;

    vec_t tbl [9];

    // Reference model state for the random phase
    logic        pw [2];  logic [11:0] pwa [2];  logic [63:0] pwd [2];
    logic        pr [2];  logic [11:0] pra [2];
    int          wprio, rprio, cyc;
    logic        prev_wv; logic [11:0] prev_wa;
    bit          sh_flag [0:4095];
    logic [63:0] sh_mem  [0:4095];
    logic        ret_v [8]; int ret_id [8]; logic [63:0] ret_d [8];

    initial begin
        logic [63:0] dv;
        int n0, n1, j, ww, rw;
        logic [11:0] ex_addr [16];
        logic blk0, blk1, e0, e1, ev0, ev1;

        idle();
        reset_n = 1'b0;
        tick();

        // Reset state with every request raised: no grants, all RAM controls clear
        bus.wr_req0 = 1'b1; bus.wr_req1 = 1'b1; bus.rd_req0 = 1'b1; bus.rd_req1 = 1'b1;
        half();
        chk("rst_wr_gnt", {bus.wr_gnt0, bus.wr_gnt1}, 2'b00);
        chk("rst_rd_gnt", {bus.rd_gnt0, bus.rd_gnt1}, 2'b00);
        chk("rst_ctrl", {bus.wren_a, bus.rden_b, bus.rd_valid0, bus.rd_valid1}, 4'b0000);
        chk("rst_addr", {bus.address_a, bus.address_b}, 24'h0);
        chk("rst_data_a", bus.data_a, 64'h0);
        do_reset();

        // Directed vectors, one cycle each; the expected values carry pointer and collision history
        tbl[0] = '{1'b1,1'b1,12'h010, 1'b0,1'b0,12'h000,12'h000, 1'b1,1'b0,1'b0,1'b0, 1'b0,12'h000,1'b0};
        tbl[1] = '{1'b1,1'b1,12'h010, 1'b0,1'b0,12'h000,12'h000, 1'b0,1'b1,1'b0,1'b0, 1'b1,12'h010,1'b0};
        tbl[2] = '{1'b0,1'b0,12'h010, 1'b1,1'b1,12'h020,12'h100, 1'b0,1'b0,1'b0,1'b1, 1'b1,12'h020,1'b0};
        tbl[3] = '{1'b0,1'b0,12'h010, 1'b1,1'b1,12'h020,12'h100, 1'b0,1'b0,1'b1,1'b0, 1'b0,12'h020,1'b1};
        tbl[4] = '{1'b0,1'b0,12'h010, 1'b1,1'b1,12'h020,12'h100, 1'b0,1'b0,1'b0,1'b1, 1'b0,12'h020,1'b1};
        tbl[5] = '{1'b1,1'b0,12'h030, 1'b1,1'b0,12'h030,12'h100, 1'b1,1'b0,1'b0,1'b0, 1'b0,12'h020,1'b1};
        tbl[6] = '{1'b0,1'b1,12'h030, 1'b1,1'b0,12'h030,12'h100, 1'b0,1'b1,1'b0,1'b0, 1'b1,12'h030,1'b0};
        tbl[7] = '{1'b0,1'b0,12'h030, 1'b1,1'b0,12'h030,12'h100, 1'b0,1'b0,1'b1,1'b0, 1'b1,12'h020,1'b0};
        tbl[8] = '{1'b1,1'b1,12'h010, 1'b1,1'b1,12'h040,12'h050, 1'b1,1'b0,1'b0,1'b1, 1'b0,12'h020,1'b1};
        for (int i = 0; i < 9; i++) begin
            bus.wr_req0 = tbl[i].wq0; bus.wr_req1 = tbl[i].wq1;
            bus.wr_addr0 = tbl[i].wa0; bus.wr_addr1 = 12'h020;
            bus.rd_req0 = tbl[i].rq0; bus.rd_req1 = tbl[i].rq1;
            bus.rd_addr0 = tbl[i].ra0; bus.rd_addr1 = tbl[i].ra1;
            half();
            chk($sformatf("vec%0d_gnt", i), {bus.wr_gnt0, bus.wr_gnt1, bus.rd_gnt0, bus.rd_gnt1},
                {tbl[i].eg0, tbl[i].eg1, tbl[i].er0, tbl[i].er1});
            chk($sformatf("vec%0d_ctrl", i), {bus.wren_a, bus.rden_b, bus.address_a},
                {tbl[i].ewren, tbl[i].erden, tbl[i].eaa});
            tick();
        end
        do_reset();

        // Write priority: continuous requests alternate starting with requester 0
        bus.wr_req0 = 1'b1; bus.wr_req1 = 1'b1; bus.wr_addr0 = 12'h010; bus.wr_addr1 = 12'h020;
        for (int k = 0; k < 6; k++) begin
            half();
            chk($sformatf("wprio_gnt%0d", k), {bus.wr_gnt0, bus.wr_gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k > 0) chk($sformatf("wprio_port_a%0d", k), {bus.wren_a, bus.address_a},
                           {1'b1, ((k % 2 == 1) ? 12'h010 : 12'h020)});
            tick();
        end
        do_reset();

        // Read after write: data written at T is read back by requester 1 at T+3
        bus.wr_req0 = 1'b1; bus.wr_addr0 = 12'h005; bus.wr_data0 = 64'hDEADBEEF_CAFEF00D;
        half();
        chk("raw_wr_gnt", bus.wr_gnt0, 1'b1);
        tick(); bus.wr_req0 = 1'b0;
        tick(); tick();
        bus.rd_req1 = 1'b1; bus.rd_addr1 = 12'h005;
        half();
        chk("raw_rd_gnt", {bus.rd_gnt0, bus.rd_gnt1}, 2'b01);
        tick(); bus.rd_req1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            half();
            chk($sformatf("raw_valid_t%0d", k), {bus.rd_valid0, bus.rd_valid1}, (k == 3) ? 2'b01 : 2'b00);
            if (k == 3) chk("raw_data", bus.rd_data, 64'hDEADBEEF_CAFEF00D);
            tick();
        end
        do_reset();

        // Collision: rd0 matches the write and stalls until T+2; rd1 at another address goes through at T
        dv = 64'h0123_4567_89AB_CDEF;
        bus.wr_req0 = 1'b1; bus.wr_addr0 = 12'h040; bus.wr_data0 = dv;
        bus.rd_req0 = 1'b1; bus.rd_addr0 = 12'h040;
        bus.rd_req1 = 1'b1; bus.rd_addr1 = 12'h041;
        half();
        chk("coll_t0_gnt", {bus.wr_gnt0, bus.rd_gnt0, bus.rd_gnt1}, 3'b101);
        tick(); bus.wr_req0 = 1'b0; bus.rd_req1 = 1'b0;
        half();
        chk("coll_t1_gnt", bus.rd_gnt0, 1'b0);
        tick();
        half();
        chk("coll_t2_gnt", bus.rd_gnt0, 1'b1);
        tick(); bus.rd_req0 = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            half();
            chk($sformatf("coll_valid_t%0d", k), {bus.rd_valid0, bus.rd_valid1},
                (k == 3) ? 2'b01 : ((k == 5) ? 2'b10 : 2'b00));
            if (k == 3) chk("coll_data_rd1", bus.rd_data, pat(12'h041));
            if (k == 5) chk("coll_data_rd0", bus.rd_data, dv);
            tick();
        end
        do_reset();

        // Streaming reads: 16 alternating grants, each returning at grant+3
        n0 = 0; n1 = 0;
        for (int c = 0; c < 20; c++) begin
            bus.rd_req0 = (c < 16); bus.rd_req1 = (c < 16);
            bus.rd_addr0 = 12'h100 + 12'(n0); bus.rd_addr1 = 12'h200 + 12'(n1);
            half();
            if (c < 16) begin
                chk($sformatf("stream_gnt%0d", c), {bus.rd_gnt0, bus.rd_gnt1}, (c % 2 == 0) ? 2'b10 : 2'b01);
                if (c % 2 == 0) begin ex_addr[c] = 12'h100 + 12'(n0); n0++; end
                else begin ex_addr[c] = 12'h200 + 12'(n1); n1++; end
            end
            j = c - 3;
            ev0 = (j >= 0) && (j < 16) && (j % 2 == 0);
            ev1 = (j >= 0) && (j < 16) && (j % 2 == 1);
            chk($sformatf("stream_valid%0d", c), {bus.rd_valid0, bus.rd_valid1}, {ev0, ev1});
            if (ev0 || ev1) chk($sformatf("stream_data%0d", c), bus.rd_data, pat(ex_addr[j]));
            tick();
        end
        do_reset();

        // Reset mid-operation: two reads in flight are dropped and priority returns to requester 0
        bus.rd_req0 = 1'b1; bus.rd_addr0 = 12'h100;
        half();
        chk("mid_gnt0", bus.rd_gnt0, 1'b1);
        tick(); bus.rd_req0 = 1'b0; bus.rd_req1 = 1'b1; bus.rd_addr1 = 12'h200;
        half();
        chk("mid_gnt1", bus.rd_gnt1, 1'b1);
        tick(); bus.rd_req1 = 1'b0; reset_n = 1'b0;
        half();
        chk("mid_rst_ctrl", {bus.wren_a, bus.rden_b, bus.address_b, bus.address_a}, 26'h0);
        tick(); reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            half();
            chk($sformatf("mid_no_valid%0d", k), {bus.rd_valid0, bus.rd_valid1}, 2'b00);
            tick();
        end
        bus.wr_req0 = 1'b1; bus.wr_req1 = 1'b1; bus.wr_addr0 = 12'h0A0; bus.wr_addr1 = 12'h0B0;
        bus.rd_req0 = 1'b1; bus.rd_req1 = 1'b1; bus.rd_addr0 = 12'h0C0; bus.rd_addr1 = 12'h0D0;
        half();
        chk("mid_prio", {bus.wr_gnt0, bus.wr_gnt1, bus.rd_gnt0, bus.rd_gnt1}, 4'b1010);
        do_reset();

        // Random traffic against the reference model, on addresses 0x300..0x307 so collisions are frequent
        for (int k = 0; k < 2; k++) begin pw[k] = 1'b0; pr[k] = 1'b0; pwa[k] = '0; pwd[k] = '0; pra[k] = '0; end
        for (int k = 0; k < 8; k++) begin ret_v[k] = 1'b0; ret_id[k] = 0; ret_d[k] = '0; end
        wprio = 0; rprio = 0; cyc = 0; prev_wv = 1'b0; prev_wa = '0;
        for (int it = 0; it < 600; it++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pw[k] && it < 590 && $urandom_range(0, 2) == 0) begin
                    pw[k] = 1'b1; pwa[k] = 12'h300 + 12'($urandom_range(0, 7)); pwd[k] = {$urandom, $urandom};
                end
                if (!pr[k] && it < 590 && $urandom_range(0, 1) == 0) begin
                    pr[k] = 1'b1; pra[k] = 12'h300 + 12'($urandom_range(0, 7));
                end
            end
            bus.wr_req0 = pw[0]; bus.wr_addr0 = pwa[0]; bus.wr_data0 = pwd[0];
            bus.wr_req1 = pw[1]; bus.wr_addr1 = pwa[1]; bus.wr_data1 = pwd[1];
            bus.rd_req0 = pr[0]; bus.rd_addr0 = pra[0];
            bus.rd_req1 = pr[1]; bus.rd_addr1 = pra[1];
            half();
            // Expected winners: -1 means no grant
            ww = (pw[0] && pw[1]) ? wprio : (pw[0] ? 0 : (pw[1] ? 1 : -1));
            blk0 = (ww >= 0 && pra[0] == pwa[ww]) || (prev_wv && pra[0] == prev_wa);
            blk1 = (ww >= 0 && pra[1] == pwa[ww]) || (prev_wv && pra[1] == prev_wa);
            e0 = pr[0] && !blk0;
            e1 = pr[1] && !blk1;
            rw = (e0 && e1) ? rprio : (e0 ? 0 : (e1 ? 1 : -1));
            chk("rnd_wr_gnt", {bus.wr_gnt0, bus.wr_gnt1}, {ww == 0, ww == 1});
            chk("rnd_rd_gnt", {bus.rd_gnt0, bus.rd_gnt1}, {rw == 0, rw == 1});
            j = cyc % 8;
            chk("rnd_valid", {bus.rd_valid0, bus.rd_valid1}, {ret_v[j] && ret_id[j] == 0, ret_v[j] && ret_id[j] == 1});
            if (ret_v[j]) chk("rnd_data", bus.rd_data, ret_d[j]);
            ret_v[j] = 1'b0;
            if (rw >= 0) begin
                j = (cyc + 3) % 8;
                ret_v[j] = 1'b1; ret_id[j] = rw;
                ret_d[j] = sh_flag[pra[rw]] ? sh_mem[pra[rw]] : pat(pra[rw]);
                pr[rw] = 1'b0; rprio = 1 - rw;
            end
            if (ww >= 0) begin
                sh_mem[pwa[ww]] = pwd[ww]; sh_flag[pwa[ww]] = 1'b1;
                prev_wv = 1'b1; prev_wa = pwa[ww];
                pw[ww] = 1'b0; wprio = 1 - ww;
            end else begin
                prev_wv = 1'b0;
            end
            cyc++;
            tick();
        end

        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
